// File: rtl/resultado_bcd_if.sv
// resultado_bcd_if: handshake and data bundle around the BCD formatter.
//   Upstream side : in_valid/in_ready, Resultado, Signo, C_out
//   Downstream side: out_valid/out_ready, decenas, unidades, neg, flag_z, flag_c
//   Status        : ocupado
// slave  = the formatter block, master = whoever drives it (subtractor/display).
interface resultado_bcd_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Resultado;
  logic             Signo;
  logic             C_out;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       decenas;
  logic [3:0]       unidades;
  logic             neg;
  logic             flag_z;
  logic             flag_c;
  logic             ocupado;

  modport slave (
    input  in_valid, Resultado, Signo, C_out, out_ready,
    output in_ready, out_valid, decenas, unidades, neg, flag_z, flag_c, ocupado
  );

  modport master (
    output in_valid, Resultado, Signo, C_out, out_ready,
    input  in_ready, out_valid, decenas, unidades, neg, flag_z, flag_c, ocupado
  );
endinterface

// File: rtl/resultado_bcd.sv
// resultado_bcd: takes one subtractor result (magnitude, sign, carry) per
// handshake, converts the magnitude to two BCD digits with a one-step-per-
// cycle double-dabble engine, and presents digits plus N/Z/C flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : resultado_bcd_if.slave (in/out valid-ready, data, flags, ocupado)
// Latency: accept at edge E, out_valid after edge E+WIDTH.
module resultado_bcd #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  resultado_bcd_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [7:0]       bcd;
  logic [CW-1:0]    cnt;
  logic             cap_sig, cap_c, cap_z;
  logic [3:0]       dec_q, uni_q;
  logic             neg_q, z_q, c_q;

  // One double-dabble step: add-3 on nibbles >= 5, then shift {bcd,sh}.
  // The bit shifted out of the top is always 0 for magnitudes <= 63.
  logic [7:0]         adj;
  logic [8+WIDTH-1:0] step;
  logic [7:0]         bcd_nxt;
  logic [WIDTH-1:0]   sh_nxt;

  always_comb begin
    adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    step     = {adj, sh} << 1;
    bcd_nxt  = step[8+WIDTH-1:WIDTH];
    sh_nxt   = step[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      cap_sig <= 1'b0;
      cap_c   <= 1'b0;
      cap_z   <= 1'b0;
      dec_q   <= '0;
      uni_q   <= '0;
      neg_q   <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sh      <= bus.Resultado;
          cap_sig <= bus.Signo;
          cap_c   <= bus.C_out;
          cap_z   <= (bus.Resultado == '0);
          bcd     <= '0;
          cnt     <= '0;
          state   <= CONV;
        end
        CONV: begin
          sh  <= sh_nxt;
          bcd <= bcd_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Digits and flags publish together on DONE entry and then hold.
            state <= DONE;
            dec_q <= bcd_nxt[7:4];
            uni_q <= bcd_nxt[3:0];
            z_q   <= cap_z;
            neg_q <= cap_sig & ~cap_z;  // -0 shows as +0
            c_q   <= cap_c;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ocupado   = (state == CONV);
  assign bus.decenas   = dec_q;
  assign bus.unidades  = uni_q;
  assign bus.neg       = neg_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;

endmodule

// File: tb/tb_resultado_bcd.sv
// tb_resultado_bcd: directed + randomized bench for resultado_bcd (WIDTH=4).
// Expected digits/flags come from plain arithmetic on the magnitude.
module tb_resultado_bcd;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  resultado_bcd_if #(.WIDTH(W)) bus();
  resultado_bcd #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int hs    = 0;
  int cyc   = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.out_valid && bus.out_ready) hs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: magnitude -> tens/units, zero flag, sign suppressed on zero.
  task automatic chk_out(input string tag, input int mag, input bit sg, input bit c);
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".dec"},   bus.decenas,  mag / 10);
    chk({tag, ".uni"},   bus.unidades, mag % 10);
    chk({tag, ".z"},     bus.flag_z,   (mag == 0) ? 1 : 0);
    chk({tag, ".neg"},   bus.neg,      (sg && mag != 0) ? 1 : 0);
    chk({tag, ".c"},     bus.flag_c,   c);
  endtask

  // Present inputs with in_valid=1 and step through the accepting edge.
  task automatic accept(input string tag, input int mag, input bit sg, input bit c);
    int n = 0;
    bus.Resultado = mag[W-1:0];
    bus.Signo     = sg;
    bus.C_out     = c;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk({tag, ".rdy_timeout"}, bus.in_ready, 1);
    tick();
  endtask

  // Wait for out_valid; returns edges since acceptance, ocupado checked meanwhile.
  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      chk({tag, ".busy"}, bus.ocupado, 1);
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, hs0, last_acc, seen;
    bit sg, c;
    int mag, d;

    bus.in_valid = 0; bus.Resultado = '0; bus.Signo = 0; bus.C_out = 0; bus.out_ready = 0;

    // Reset
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.ocupado", bus.ocupado, 0);
    chk("rst.dec", bus.decenas, 0);
    chk("rst.uni", bus.unidades, 0);
    chk("rst.neg", bus.neg, 0);
    chk("rst.z", bus.flag_z, 0);
    chk("rst.c", bus.flag_c, 0);

    // Negative result 13
    bus.out_ready = 1;
    accept("neg13", 13, 1, 0);
    bus.in_valid = 0;
    wait_out("neg13", lat);
    chk("neg13.lat", lat, W);
    chk_out("neg13", 13, 1, 0);
    tick();
    chk("neg13.idle", bus.in_ready, 1);
    chk("neg13.ov_low", bus.out_valid, 0);

    // Negative zero
    accept("negz", 0, 1, 1);
    bus.in_valid = 0;
    wait_out("negz", lat);
    chk("negz.lat", lat, W);
    chk_out("negz", 0, 1, 1);
    tick();

    // Backpressure: 9 held in DONE while pins move to 15
    bus.out_ready = 0;
    accept("bp9", 9, 0, 0);
    bus.Resultado = 4'd15;
    wait_out("bp9", lat);
    chk_out("bp9", 9, 0, 0);
    repeat (6) begin
      tick();
      chk("bp.valid", bus.out_valid, 1);
      chk("bp.dec", bus.decenas, 0);
      chk("bp.uni", bus.unidades, 9);
      chk("bp.in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    tick();
    chk("bp.idle_no_accept", bus.in_ready, 1);
    tick();
    chk("bp.accept15", bus.ocupado, 1);
    bus.in_valid = 0;
    wait_out("bp15", lat);
    chk_out("bp15", 15, 0, 0);
    tick();

    // Exhaustive sweep with in_valid held high throughout
    hs0 = hs;
    last_acc = 0;
    for (int i = 0; i < 32; i++) begin
      accept("sweep", i % 16, (i >= 16), i[0]);
      if (i > 0) chk("sweep.spacing", cyc - last_acc, W + 2);
      last_acc = cyc;
      wait_out("sweep", lat);
      chk("sweep.lat", lat, W);
      chk_out("sweep", i % 16, (i >= 16), i[0]);
    end
    bus.in_valid = 0;
    tick();
    chk("sweep.handshakes", hs - hs0, 32);
    tick();
    chk("sweep.no_double", bus.ocupado, 0);

    // Randomized results with random backpressure
    for (int i = 0; i < 24; i++) begin
      mag = $urandom_range(0, 15);
      sg  = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 3);
      bus.out_ready = 0;
      accept("rnd", mag, sg, c);
      bus.in_valid  = 0;
      bus.Resultado = 4'($urandom);
      bus.Signo     = 1'($urandom);
      wait_out("rnd", lat);
      chk("rnd.lat", lat, W);
      chk_out("rnd", mag, sg, c);
      repeat (d) begin
        tick();
        chk("rnd.hold_uni", bus.unidades, mag % 10);
      end
      bus.out_ready = 1;
      tick();
      chk("rnd.released", bus.out_valid, 0);
    end

    // Reset in the 2nd CONV cycle of 11
    accept("mid11", 11, 0, 0);
    bus.in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("mid.ov", bus.out_valid, 0);
    chk("mid.dec", bus.decenas, 0);
    chk("mid.uni", bus.unidades, 0);
    chk("mid.busy", bus.ocupado, 0);
    tick();
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("mid.never_valid", seen, 0);
    chk("mid.in_ready", bus.in_ready, 1);
    chk("mid.uni_after", bus.unidades, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/resultado_bcd.md
# resultado_bcd

Downstream stage of the 4-bit subtractor (`Restador`). It accepts one subtraction result per valid/ready handshake: magnitude, sign and carry-out. It converts the magnitude to two BCD digits with a sequential shift-add-3 (double-dabble) engine and registers the N/Z/C flags. It then presents the formatted result on a valid/ready output port that feeds the display and flag logic.

## Interface
- `WIDTH`, default 4: magnitude width of `Resultado`. Legal range is 4..6, so the magnitude is at most 63 and always fits two BCD digits.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream result present.
- `in_ready` out 1: block can accept; equals (state == IDLE).
- `Resultado` in WIDTH: magnitude of A−B from the subtractor.
- `Signo` in 1: 1 = result negative (A < B).
- `C_out` in 1: raw carry-out of the subtractor.
- `out_valid` out 1: formatted result available.
- `out_ready` in 1: downstream accepts.
- `decenas` out 4: BCD tens digit.
- `unidades` out 4: BCD units digit.
- `neg` out 1: sign to display.
- `flag_z` out 1: result magnitude is zero.
- `flag_c` out 1: registered `C_out`.
- `ocupado` out 1: conversion in progress (state == CONV).

## Operation
- **States:** IDLE, CONV, DONE. Reset forces IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`=1 at an edge, capture `Resultado` into shift register `sh`, capture `Signo` and `C_out`, clear the 8-bit BCD accumulator `bcd`, set the cycle counter to 0, and go to CONV.
- **CONV:** one double-dabble step per cycle.
  - First, each nibble of `bcd` that is ≥5 gets +3.
  - Then {`bcd`,`sh`} shifts left by 1.
  - The counter increments. After the WIDTH-th step, go to DONE.
- **Entry to DONE (same edge as the last step):** `decenas`, `unidades`, `flag_z`, `neg` and `flag_c` update together.
  - `flag_z` = (captured magnitude == 0).
  - `neg` = captured `Signo` AND NOT `flag_z`. Negative zero always displays as +0.
  - `flag_c` = captured `C_out`.
- **DONE:**
  - `out_valid`=1 and `in_ready`=0.
  - On `out_ready`=1 at an edge, go to IDLE.
  - Output data and flags hold until the next DONE entry; they do not clear on handshake.
- **Input sampling:** `Resultado`, `Signo` and `C_out` are sampled only on the accepting edge. Later changes during CONV or DONE have no effect.
- **Simultaneous events:** `in_valid`=1 in the same cycle as the DONE→IDLE handshake is not accepted. It is accepted on the following edge, once in IDLE. `in_valid` during CONV or DONE is ignored (no buffering). Upstream must hold `in_valid` until `in_ready`.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, all outputs are stable.

## Timing
- **Reset values** (`rst_n`=0, asynchronous):
  - State IDLE, `in_ready`=1, `out_valid`=0, `ocupado`=0.
  - `decenas`=0, `unidades`=0, `neg`=0, `flag_z`=0, `flag_c`=0.
  - Internal `sh`, `bcd` and counter = 0.
- **Reset mid-operation:** asserting `rst_n` during CONV or DONE aborts the operation immediately. The in-flight result is discarded and is never presented.
- **Latency:** acceptance edge E. `ocupado`=1 for cycles E+1..E+WIDTH. `out_valid` rises after edge E+WIDTH. With WIDTH=4, `out_valid` is 1 in the 5th cycle after acceptance.
- **Throughput:** the minimum spacing between accepted inputs is WIDTH+2 edges, when `out_ready` is held at 1.
- **Handshake timing:** `in_ready` and `out_valid` are decoded from registered state, with no combinational path from `in_valid` or `out_ready`.
- **Counter:** width is `$clog2(WIDTH+1)`. No wrap is possible, because the counter resets on each acceptance.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs at their reset values, `in_ready`=1, `out_valid`=0.
- **Negative result:** WIDTH=4, `Resultado`=4'd13, `Signo`=1, `C_out`=0, `out_ready`=1 → exactly 4 cycles later `out_valid`=1 with `decenas`=1, `unidades`=3, `neg`=1, `flag_z`=0, `flag_c`=0. Back in IDLE one edge later.
- **Negative zero:** `Resultado`=0, `Signo`=1, `C_out`=1 → `decenas`=0, `unidades`=0, `neg`=0, `flag_z`=1, `flag_c`=1.
- **Backpressure:** `Resultado`=9 with `out_ready`=0 for 6 cycles, while the input pins change to 15 → `out_valid` stays 1, the outputs stay 0/9 and `in_ready`=0. After `out_ready`=1, the next accepted value is 15, giving 1/5.
- **Exhaustive sweep:** all 16 magnitudes × `Signo` 0/1 back-to-back, `out_ready`=1 → each output matches magnitude/10 and magnitude%10. `in_valid` held during CONV is never double-accepted, and there are 32 output handshakes total.
- **Reset mid-operation:** assert `rst_n`=0 on the 2nd CONV cycle of `Resultado`=11 → `out_valid` never rises, and the outputs remain at the previous/reset values.
